sync_filter: RTL and testbench
==============================

Name: sync_filter

Overview:
Multi-channel clock-domain-crossing synchroniser with a per-channel glitch filter and edge detection. Each asynchronous input bit passes through a Stages-deep flip-flop chain. Its filtered output changes level only after the synchronised value has differed from it for FilterCycles consecutive cycles. Registered one-cycle rise/fall pulses accompany every filtered transition. Used for pad-level straps, interrupts and button/status lines entering a clock domain.

Parameters:
NumChannels, 1, number of independent input bits (>=1)
Stages, 2, synchroniser flip-flop depth (>=2; elaboration error otherwise)
ResetValue, '0, NumChannels-bit vector; per-channel reset/clear value of synchroniser chain and filtered level
FilterCycles, 1, consecutive mismatching cycles required before filtered level updates (>=1; 1 = no filtering beyond one register)

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, synchronous, active-low
clr_i  input  1  synchronous clear; same effect as reset
serial_i  input  NumChannels  asynchronous inputs
serial_o  output  NumChannels  filtered, synchronised level
rise_o  output  NumChannels  one-cycle pulse: serial_o went 0->1 this cycle
fall_o  output  NumChannels  one-cycle pulse: serial_o went 1->0 this cycle

Behaviour:
- Single clock clk_i. Reset is synchronous and active-low on rst_ni, sampled at clk_i rising edge. rst_ni has priority over clr_i.
- Reset or clr_i, per channel c:
  - every chain stage = ResetValue[c]
  - serial_o[c] = ResetValue[c]
  - filter counter = 0
  - rise_o = fall_o = 0
- No edge pulse is produced on reset or clear, even if serial_o changes value.
- Synchroniser: chain shifts serial_i[c] in each cycle. s[c] = last stage. Carry async_reg/dont_touch attributes on chain flops. No logic between stages.
- Filter, per channel, counter cnt width $clog2(FilterCycles) (min 1 bit):
  - s==serial_o: cnt <= 0.
  - s!=serial_o and cnt<FilterCycles-1: cnt <= cnt+1.
  - s!=serial_o and cnt==FilterCycles-1: serial_o <= s, cnt <= 0. This is an "update".
  - A mismatch interrupted by even one matching cycle restarts the count from 0.
- Edges: rise_o[c] <= update & s[c]; fall_o[c] <= update & ~s[c]. Pulses are high exactly in the cycle serial_o first shows the new value, and last exactly one cycle.
- Latency: input stable before edge 1 -> s valid after edge Stages -> serial_o changes after edge Stages+FilterCycles.
- Back-to-back updates:
  - Minimum spacing between updates on one channel = FilterCycles cycles.
  - A rise and a fall on the same channel are never high in the same cycle.
- Channels are fully independent. Simultaneous events on different channels are handled in parallel without interaction.
- Counter never wraps; its maximum value is FilterCycles-1.
- Outputs are driven directly from flops; no combinational path from serial_i to any output.

Test Plan:
- Reset: NumChannels=4, ResetValue=4'b1010, hold rst_ni=0 3 cycles with serial_i=4'b0101 -> serial_o=4'b1010, rise_o=fall_o=0 throughout and in the cycle after release.
- Clean step: Stages=2, FilterCycles=4, serial_i[0] 0->1 before edge 1 -> serial_o[0] and rise_o[0] high after edge 6. rise_o[0] low after edge 7. FilterCycles=1 -> change after edge 3.
- Glitch rejection: FilterCycles=4, serial_i[1] high for 3 cycles, then low -> serial_o[1] stays 0, no rise_o/fall_o. Same pulse held for 4 cycles -> one rise_o, then fall_o exactly 4 cycles after it.
- Restart: FilterCycles=4, input high 2 cycles, low 1, high 4 -> exactly one update, occurring after the final 4-cycle run completes.
- Concurrency: channel 0 rises while channel 2 falls in the same cycle -> rise_o=4'b0001 and fall_o=4'b0100 in the same cycle.
- Clear/reset mid-operation: assert clr_i with cnt=2 pending a rise -> serial_o=ResetValue, no pulse, count restarts. Input still high -> update after another Stages+FilterCycles edges. Repeat with rst_ni: identical result. rst_ni=0 with clr_i=1 behaves as reset.

Source files
------------

// File: rtl/sync_filter.sv
// Multi-channel CDC synchroniser with per-channel glitch filter and registered
// rise/fall pulses on every filtered transition.
module sync_filter #(
    parameter int unsigned                NumChannels  = 1,
    parameter int unsigned                Stages       = 2,
    parameter logic [NumChannels-1:0]     ResetValue   = '0,
    parameter int unsigned                FilterCycles = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  logic [NumChannels-1:0] serial_i,
    output logic [NumChannels-1:0] serial_o,
    output logic [NumChannels-1:0] rise_o,
    output logic [NumChannels-1:0] fall_o
);

    localparam int unsigned CntW = (FilterCycles > 1) ? $clog2(FilterCycles) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

    if (Stages < 2) begin : g_bad_stages
        $error("sync_filter: Stages must be >= 2");
    end
    if (FilterCycles < 1) begin : g_bad_filter
        $error("sync_filter: FilterCycles must be >= 1");
    end
    if (NumChannels < 1) begin : g_bad_channels
        $error("sync_filter: NumChannels must be >= 1");
    end

    (* async_reg = "true", dont_touch = "true" *)
    logic [NumChannels-1:0] sync_q [Stages];

    logic [NumChannels-1:0] sync_s;
    logic [NumChannels-1:0] level_q, level_d;
    logic [NumChannels-1:0] update;
    logic [NumChannels-1:0] rise_q, fall_q;
    logic [CntW-1:0]        cnt_q [NumChannels];
    logic [CntW-1:0]        cnt_d [NumChannels];

    // Plain flop chain: nothing may sit between stages.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            for (int i = 0; i < Stages; i++) begin
                sync_q[i] <= ResetValue;
            end
        end else begin
            sync_q[0] <= serial_i;
            for (int i = 1; i < Stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_s = sync_q[Stages-1];

    always_comb begin
        update = '0;
        for (int c = 0; c < NumChannels; c++) begin
            cnt_d[c] = '0;
            if (sync_s[c] != level_q[c]) begin
                if (cnt_q[c] == CntMax) begin
                    update[c] = 1'b1;
                end else begin
                    cnt_d[c] = cnt_q[c] + CntW'(1);
                end
            end
        end
        level_d = level_q ^ update;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            level_q <= ResetValue;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int c = 0; c < NumChannels; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            level_q <= level_d;
            rise_q  <= update & sync_s;
            fall_q  <= update & ~sync_s;
            for (int c = 0; c < NumChannels; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign serial_o = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: tb/tb_sync_filter.sv
// Self-checking bench for sync_filter: directed literal scenarios plus random
// stimulus compared every cycle against a run-length behavioural model.
module tb_sync_filter;

    localparam int unsigned NC = 4;
    localparam int unsigned ST = 2;
    localparam int unsigned FC = 4;
    localparam logic [NC-1:0] RV = 4'b1010;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic [NC-1:0] din = 4'b0101;
    logic [NC-1:0] dout, rise, fall;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    sync_filter #(
        .NumChannels (NC),
        .Stages      (ST),
        .ResetValue  (RV),
        .FilterCycles(FC)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (clr),
        .serial_i(din),
        .serial_o(dout),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NC-1:0] act, input logic [NC-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Model: inputs reach the filter after ST edges; the level flips once the
    // synchronised value has disagreed with it for FC consecutive edges.
    logic [NC-1:0] m_hist [$];
    logic [NC-1:0] m_level = RV;
    logic [NC-1:0] m_rise = '0;
    logic [NC-1:0] m_fall = '0;
    int            m_run [NC];

    initial begin
        for (int i = 0; i < int'(ST); i++) m_hist.push_back(RV);
        for (int c = 0; c < int'(NC); c++) m_run[c] = 0;
    end

    always @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < int'(ST); i++) m_hist[i] = RV;
            m_level = RV;
            m_rise  = '0;
            m_fall  = '0;
            for (int c = 0; c < int'(NC); c++) m_run[c] = 0;
        end else begin
            logic [NC-1:0] s;
            s      = m_hist[ST-1];
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < int'(NC); c++) begin
                m_run[c] = (s[c] != m_level[c]) ? m_run[c] + 1 : 0;
                if (m_run[c] == int'(FC)) begin
                    m_level[c] = s[c];
                    m_rise[c]  = s[c];
                    m_fall[c]  = ~s[c];
                    m_run[c]   = 0;
                end
            end
            void'(m_hist.pop_back());
            m_hist.push_front(din);
        end
    end

    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            chk("model_level", dout, m_level);
            chk("model_rise", rise, m_rise);
            chk("model_fall", fall, m_fall);
            checks++;
            if ((rise & fall) != '0) begin
                errors++;
                $display("FAIL rise_fall_overlap at %0t: got %b expected 0000", $time, rise & fall);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Apply a pending-rise then a given reset/clear combination, check recovery.
    task automatic abort_pending(input logic use_rst, input logic use_clr, input string name);
        din = 4'b1010;
        tick(12);
        din = 4'b1111;
        tick(4);
        if (use_rst) rst_n = 1'b0;
        if (use_clr) clr = 1'b1;
        tick(1);
        chk({name, "_level"}, dout, 4'b1010);
        chk({name, "_rise"}, rise, 4'b0000);
        chk({name, "_fall"}, fall, 4'b0000);
        rst_n = 1'b1;
        clr   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk({name, "_no_early_rise"}, rise, 4'b0000);
        end
        tick(1);
        chk({name, "_rise_after"}, rise, 4'b0101);
        chk({name, "_level_after"}, dout, 4'b1111);
    endtask

    initial begin
        int hold [NC];

        // Reset held for 3 cycles with inputs opposite to the reset value.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            cmp_en = 1'b1;
            chk("reset_level", dout, 4'b1010);
            chk("reset_rise", rise, 4'b0000);
            chk("reset_fall", fall, 4'b0000);
        end
        din   = 4'b1010;
        rst_n = 1'b1;
        tick(1);
        chk("release_rise", rise, 4'b0000);
        chk("release_fall", fall, 4'b0000);
        tick(8);

        // Clean step on channel 0: update after edge ST+FC = 6.
        din = 4'b1011;
        tick(5);
        chk("step_not_yet", dout, 4'b1010);
        tick(1);
        chk("step_level", dout, 4'b1011);
        chk("step_rise", rise, 4'b0001);
        tick(1);
        chk("step_rise_gone", rise, 4'b0000);
        tick(4);

        // Three-cycle low glitch is rejected.
        din = 4'b1010;
        tick(3);
        din = 4'b1011;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("glitch_level", dout, 4'b1011);
            chk("glitch_fall", fall, 4'b0000);
        end

        // Four-cycle low pulse: fall, then rise exactly 4 cycles later.
        din = 4'b1010;
        tick(4);
        din = 4'b1011;
        tick(1);
        chk("pulse_no_fall", fall, 4'b0000);
        tick(1);
        chk("pulse_fall", fall, 4'b0001);
        chk("pulse_low", dout, 4'b1010);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("pulse_no_rise", rise, 4'b0000);
        end
        tick(1);
        chk("pulse_rise", rise, 4'b0001);
        chk("pulse_high", dout, 4'b1011);
        tick(6);

        // Restart: low 2, high 1, then low -> single fall at edge 9.
        din = 4'b1010;
        tick(2);
        din = 4'b1011;
        tick(1);
        din = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("restart_no_fall", fall, 4'b0000);
        end
        tick(1);
        chk("restart_fall", fall, 4'b0001);
        tick(4);

        // Bring channel 2 high, then channel 0 rises while channel 2 falls.
        din = 4'b1110;
        tick(10);
        chk("conc_setup", dout, 4'b1110);
        din = 4'b1011;
        tick(5);
        chk("conc_not_yet", rise | fall, 4'b0000);
        tick(1);
        chk("conc_rise", rise, 4'b0001);
        chk("conc_fall", fall, 4'b0100);
        tick(4);

        abort_pending(1'b0, 1'b1, "clear");
        abort_pending(1'b1, 1'b0, "reset");
        abort_pending(1'b1, 1'b1, "reset_and_clear");

        // Random stimulus with per-channel hold lengths around the filter width.
        for (int c = 0; c < int'(NC); c++) hold[c] = 1;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < int'(NC); c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    din[c]  = $urandom_range(0, 1);
                    hold[c] = $urandom_range(1, 7);
                end
            end
            clr   = ($urandom_range(0, 149) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            tick(1);
        end
        clr   = 1'b0;
        rst_n = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
